// File: rtl/axis_insert_last_if.sv
// AXI-Stream bundle (tdata/tlast/tvalid/tready) used on both sides of axis_insert_last.
// Latency: none; this file only groups wires.
// Backpressure: tready flows from slave to master, everything else from master to slave.
//
// Ports (modports):
//   master : drives tdata, tlast, tvalid; samples tready
//   slave  : samples tdata, tlast, tvalid; drives tready
interface axis_insert_last_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_insert_last.sv
// Re-frames AXI-Stream: forwards data beats with tlast cleared and appends one trailer beat (tlast=1) per frame.
// Latency: one cycle (registered output stage); each frame costs exactly one input bubble for the trailer.
// Backpressure: s_axis.tready = PASS state & output register free; never depends on s_axis.tvalid.
//
// Ports:
//   clk, rst   : single clock; rst is asynchronous, active-high
//   s_axis     : upstream stream (slave modport); tlast marks a frame's last data beat
//   m_axis     : downstream stream (master modport); tlast high only on trailer beats
//   tail_sent  : one-cycle registered pulse after each trailer handshake
// Optional build macro AXIS_INSERT_LAST_CNT_EN: when defined, the trailer's low CNT_WIDTH bits
// carry the frame's data-beat count; otherwise the trailer is TAIL_WORD.
module axis_insert_last #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    MAX_BEATS  = 1024,
    parameter logic [DATA_WIDTH-1:0] TAIL_WORD  = {DATA_WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_insert_last_if.slave          s_axis,
    axis_insert_last_if.master         m_axis,
    output logic                       tail_sent
);

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    logic [0:0]            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  free;
    logic                  s_fire;
    logic                  m_fire;
    logic                  end_frame;
    logic [DATA_WIDTH-1:0] tail_dat;

    // Output register can accept a new beat when empty or being drained this cycle.
    assign free          = !m_axis.tvalid | m_axis.tready;
    assign s_axis.tready = (state == ST_PASS) & free;
    assign s_fire        = s_axis.tvalid & s_axis.tready;
    assign m_fire        = m_axis.tvalid & m_axis.tready;
    assign cnt_inc       = cnt + CNT_WIDTH'(1);

    // A frame closes on the upstream tlast or when it reaches the forced length;
    // both together still produce a single trailer.
    assign end_frame     = s_axis.tlast | (cnt_inc == CNT_WIDTH'(MAX_BEATS));

`ifdef AXIS_INSERT_LAST_CNT_EN
    logic [CNT_WIDTH-1:0] tail_cnt;

    assign tail_dat = {TAIL_WORD[DATA_WIDTH-1:CNT_WIDTH], tail_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_cnt <= '0;
        end else if (s_fire && end_frame) begin
            tail_cnt <= cnt_inc;
        end
    end
`else
    assign tail_dat = TAIL_WORD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_PASS;
            cnt           <= '0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tvalid <= 1'b0;
            tail_sent     <= 1'b0;
        end else begin
            tail_sent <= m_fire & m_axis.tlast;

            if (state == ST_PASS) begin
                if (s_fire) begin
                    m_axis.tdata  <= s_axis.tdata;
                    m_axis.tlast  <= 1'b0;
                    m_axis.tvalid <= 1'b1;
                    if (end_frame) begin
                        cnt   <= '0;
                        state <= ST_TAIL;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else if (m_fire) begin
                    m_axis.tvalid <= 1'b0;
                end
            end else begin
                // Trailer waits for the last data beat to leave (or be leaving) the register.
                if (free) begin
                    m_axis.tdata  <= tail_dat;
                    m_axis.tlast  <= 1'b1;
                    m_axis.tvalid <= 1'b1;
                    state         <= ST_PASS;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_insert_last.sv
// Bench for axis_insert_last: directed frames plus randomized traffic against a queue-based frame model.
// Latency: model expects beats in order; the DUT's one-cycle register is tolerated by the queue.
// Backpressure: random and directed m tready patterns; stalled outputs must hold.
module tb_axis_insert_last;

    localparam int DW   = 64;
    localparam int CW   = 16;
    localparam int MAXB = 4;

    logic clk;
    logic rst;
    logic tail_sent;

    axis_insert_last_if #(.DATA_WIDTH(DW)) s_if ();
    axis_insert_last_if #(.DATA_WIDTH(DW)) m_if ();

    axis_insert_last #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .MAX_BEATS  (MAXB),
        .TAIL_WORD  ({DW{1'b1}})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master),
        .tail_sent (tail_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: expected output beats {tlast, tdata} in order.
    logic [DW:0]   q[$];
    int            mcnt;
    logic          prev_stall;
    logic [DW-1:0] prev_dat;
    logic          prev_lst;
    logic          exp_tail;
    logic          bubble;
    logic          last_sf;
    int            tr_seen;
    int            tr0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] trailer(input int n);
        logic [DW-1:0] t;
        t = '1;
`ifdef AXIS_INSERT_LAST_CNT_EN
        t[CW-1:0] = n[CW-1:0];
`endif
        return t;
    endfunction

    task automatic model_reset();
        q.delete();
        mcnt       = 0;
        prev_stall = 1'b0;
        exp_tail   = 1'b0;
        bubble     = 1'b0;
        last_sf    = 1'b0;
    endtask

    // One clock cycle: called just after a negedge, returns at the next negedge.
    task automatic cycle(input logic vld, input logic [DW-1:0] dat, input logic lst, input logic rdy);
        logic        sf;
        logic        mf;
        logic [DW:0] e;
        s_if.tvalid = vld;
        s_if.tdata  = dat;
        s_if.tlast  = lst;
        m_if.tready = rdy;
        #1;
        chk1("tail_sent", tail_sent, exp_tail);
        if (prev_stall) begin
            chk1("hold_vld", m_if.tvalid, 1'b1);
            chk("hold_dat", m_if.tdata, prev_dat);
            chk1("hold_last", m_if.tlast, prev_lst);
        end
        if (bubble) chk1("bubble_rdy", s_if.tready, 1'b0);
        if (m_if.tvalid && !rdy) chk1("stall_rdy", s_if.tready, 1'b0);
        if (m_if.tvalid) chk1("vld_pending", q.size() > 0, 1'b1);
        sf = vld & s_if.tready;
        mf = m_if.tvalid & rdy;
        if (mf && q.size() > 0) begin
            e = q.pop_front();
            chk("out_dat", m_if.tdata, e[DW-1:0]);
            chk1("out_last", m_if.tlast, e[DW]);
            if (m_if.tlast) tr_seen++;
        end
        prev_stall = m_if.tvalid & !rdy;
        prev_dat   = m_if.tdata;
        prev_lst   = m_if.tlast;
        exp_tail   = mf & m_if.tlast;
        bubble     = 1'b0;
        last_sf    = sf;
        if (sf) begin
            q.push_back({1'b0, dat});
            mcnt++;
            if (lst || mcnt == MAXB) begin
                q.push_back({1'b1, trailer(mcnt)});
                mcnt   = 0;
                bubble = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Offer one beat until accepted (bounded).
    task automatic send(input logic [DW-1:0] dat, input logic lst);
        int tries;
        tries = 0;
        cycle(1'b1, dat, lst, 1'b1);
        while (!last_sf && tries < 20) begin
            cycle(1'b1, dat, lst, 1'b1);
            tries++;
        end
        chk1("send_accepted", last_sf, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 60) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("drain_empty", DW'(q.size()), '0);
    endtask

    initial begin
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        tr_seen     = 0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        #1;
        chk1("rst_tvalid", m_if.tvalid, 1'b0);
        chk1("rst_tlast", m_if.tlast, 1'b0);
        chk("rst_tdata", m_if.tdata, '0);
        chk1("rst_tail_sent", tail_sent, 1'b0);
        chk1("rst_s_tready", s_if.tready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // 3-beat frame, downstream always ready
        tr0 = tr_seen;
        send(64'hAAAA_0000_0000_0001, 1'b0);
        send(64'hBBBB_0000_0000_0002, 1'b0);
        send(64'hCCCC_0000_0000_0003, 1'b1);
        drain();
        chk("frame3_trailers", DW'(tr_seen - tr0), DW'(1));

        // 6 beats with forced close at 4: two trailers
        tr0 = tr_seen;
        for (int i = 1; i <= 6; i++) send(DW'(64'h6000 + i), (i == 6));
        drain();
        chk("forced6_trailers", DW'(tr_seen - tr0), DW'(2));

        // tlast coincides with MAX_BEATS: one trailer; next frame starts fresh
        tr0 = tr_seen;
        for (int i = 1; i <= 4; i++) send(DW'(64'h4000 + i), (i == 4));
        drain();
        chk("coincide_trailers", DW'(tr_seen - tr0), DW'(1));
        tr0 = tr_seen;
        send(64'h5001, 1'b0);
        send(64'h5002, 1'b1);
        drain();
        chk("after_coincide_trailers", DW'(tr_seen - tr0), DW'(1));

        // Backpressure: tready 1,0,0,1 during a 2-beat frame
        tr0 = tr_seen;
        cycle(1'b1, 64'h7001, 1'b0, 1'b1);
        cycle(1'b1, 64'h7002, 1'b1, 1'b0);
        cycle(1'b1, 64'h7002, 1'b1, 1'b0);
        cycle(1'b1, 64'h7002, 1'b1, 1'b1);
        if (!last_sf) send(64'h7002, 1'b1);
        drain();
        chk("bp_trailers", DW'(tr_seen - tr0), DW'(1));

        // Reset mid-frame after 2 of 5 beats
        send(64'h8001, 1'b0);
        send(64'h8002, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk1("midrst_tvalid", m_if.tvalid, 1'b0);
        chk1("midrst_tail_sent", tail_sent, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tr0 = tr_seen;
        send(64'h9001, 1'b1);
        drain();
        chk("post_rst_trailers", DW'(tr_seen - tr0), DW'(1));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
        end
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
